// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF      = 8;
  localparam int FIFO_ADDR_WIDTH_DEF = 4;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Smallest n with 2**n >= value; for integrators sizing ADDR_WIDTH from a depth.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// WIDTH x DEPTH register array: synchronous write port, asynchronous read port.
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int WIDTH      = FIFO_WIDTH_DEF,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and selectable standard or FWFT read.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH      = FIFO_WIDTH_DEF,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = FIFO_MODE_STD
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [WIDTH-1:0]    data_in,
  input  logic                rd_en,
  output logic [WIDTH-1:0]    data_out,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDR_WIDTH:0] count,
  output logic                overflow,
  output logic                underflow,
  input  logic                clr_err
);

  localparam int                DEPTH  = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] AF_CNT = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_CNT = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] count_q;
  logic                overflow_q;
  logic                underflow_q;
  logic                wr_acc;
  logic                rd_acc;
  logic [WIDTH-1:0]    mem_rd;

  // Flags come only from registered pointers/count, never from wr_en/rd_en.
  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  fifo_mem_2p #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (data_in),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (mem_rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      if (wr_acc && !rd_acc)      count_q <= count_q + ONE;
      else if (rd_acc && !wr_acc) count_q <= count_q - ONE;
    end
  end

  // Set has priority over clr_err in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en && full)  overflow_q <= 1'b1;
      else if (clr_err)   overflow_q <= 1'b0;
      if (rd_en && empty) underflow_q <= 1'b1;
      else if (clr_err)   underflow_q <= 1'b0;
    end
  end

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign data_out = mem_rd;
  end else begin : g_std
    logic [WIDTH-1:0] data_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset)       data_q <= '0;
      else if (rd_acc) data_q <= mem_rd;
    end
    assign data_out = data_q;
  end

  initial begin : p_param_check
    if (ADDR_WIDTH < 2 || ADDR_WIDTH > 10 || AF_LEVEL < 1 || AF_LEVEL > DEPTH ||
        AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin
      $fatal(1, "sync_fifo_flags: illegal parameter set");
    end
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench: standard-read instance checked against a queue model and
// scoreboard; a second FWFT instance covers fall-through behaviour.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en, rd_en, clr_err;
  logic [7:0] data_in, data_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       f_wr_en, f_rd_en;
  logic [7:0] f_data_in, f_data_out;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [4:0] f_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  int         mcount;
  logic       movf, mudf;

  always #5 clk = ~clk;

  sync_fifo_flags #(.WIDTH(8), .ADDR_WIDTH(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_std (
    .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow), .clr_err(clr_err)
  );

  sync_fifo_flags #(.WIDTH(8), .ADDR_WIDTH(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .wr_en(f_wr_en), .data_in(f_data_in), .rd_en(f_rd_en),
    .data_out(f_data_out), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .overflow(f_ovf),
    .underflow(f_udf), .clr_err(1'b0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, ":count"}, count, mcount);
    chk({tag, ":empty"}, empty, mcount == 0);
    chk({tag, ":full"}, full, mcount == 16);
    chk({tag, ":almost_full"}, almost_full, mcount >= 14);
    chk({tag, ":almost_empty"}, almost_empty, mcount <= 2);
    chk({tag, ":overflow"}, overflow, movf);
    chk({tag, ":underflow"}, underflow, mudf);
  endtask

  // One clock of stimulus on the standard instance; model is updated from
  // the pre-edge model state and compared #1 after the edge.
  task automatic step(input string tag, input logic wr, input logic [7:0] din,
                      input logic rd, input logic clr);
    logic m_full, m_empty, ra;
    wr_en = wr; data_in = din; rd_en = rd; clr_err = clr;
    m_full  = (mcount == 16);
    m_empty = (mcount == 0);
    ra = rd && !m_empty;
    if (ra) begin
      exp_q.push_back(mq.pop_front());
      mcount--;
    end
    if (wr && !m_full) begin
      mq.push_back(din);
      mcount++;
    end
    if (wr && m_full) movf = 1'b1;
    else if (clr)     movf = 1'b0;
    if (rd && m_empty) mudf = 1'b1;
    else if (clr)      mudf = 1'b0;
    @(posedge clk);
    #1;
    chk_flags(tag);
    if (ra) chk({tag, ":data_out"}, data_out, exp_q.pop_front());
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    mcount = 0;
    movf = 1'b0;
    mudf = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    wr_en = 0; rd_en = 0; clr_err = 0; data_in = '0;
    f_wr_en = 0; f_rd_en = 0; f_data_in = '0;
    model_reset();
    #12;
    reset = 1'b0;
    #1;
    chk_flags("reset");
    chk("reset:data_out", data_out, 8'h00);

    // fill 0x00..0x0F
    for (int i = 0; i < 16; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);

    // overflow while full; 0xAA must be dropped
    step("ovf", 1'b1, 8'hAA, 1'b0, 1'b0);
    step("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // drain: scoreboard expects 0x00..0x0F one cycle after each rd_en
    for (int i = 0; i < 16; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain:hold_when_empty", data_out, 8'h0F);

    // underflow, clear, and set-wins-over-clear
    step("udf", 1'b0, 8'h00, 1'b1, 1'b0);
    step("clr", 1'b0, 8'h00, 1'b0, 1'b1);
    step("udf_clr_same", 1'b0, 8'h00, 1'b1, 1'b1);
    step("clr2", 1'b0, 8'h00, 1'b0, 1'b1);

    // count=5 then 40 simultaneous wr/rd across pointer wrap
    for (int i = 0; i < 5; i++) step("pre5", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step("simul", 1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("post5", 1'b0, 8'h00, 1'b1, 1'b0);

    // empty write+read: write taken, read rejected
    step("empty_wr_rd", 1'b1, 8'h3C, 1'b1, 1'b0);
    step("read_3c", 1'b0, 8'h00, 1'b1, 1'b1);
    step("idle2", 1'b0, 8'h00, 1'b0, 1'b0);

    // FWFT instance
    f_wr_en = 1; f_data_in = 8'h5A;
    @(posedge clk); #1;
    f_wr_en = 0;
    chk("fwft:data_out", f_data_out, 8'h5A);
    chk("fwft:empty", f_empty, 1'b0);
    @(posedge clk); #1;
    chk("fwft:data_hold", f_data_out, 8'h5A);
    f_rd_en = 1;
    @(posedge clk); #1;
    f_rd_en = 0;
    chk("fwft:pop_empty", f_empty, 1'b1);
    chk("fwft:pop_count", f_count, 5'd0);
    chk("fwft:no_udf", f_udf, 1'b0);

    // mid-burst async reset with errors set
    step("pre_udf", 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step("burst", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    step("burst_rd", 1'b1, 8'hC9, 1'b1, 1'b0);
    wr_en = 1; data_in = 8'hCA;
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    chk_flags("async_reset");
    chk("async_reset:data_out", data_out, 8'h00);
    @(posedge clk); #1;
    chk_flags("held_reset");
    wr_en = 0;
    reset = 1'b0;
    step("post_wr", 1'b1, 8'h77, 1'b0, 1'b0);
    step("post_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    step("post_idle", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("post:data_out", data_out, 8'h77);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
